// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined RV32I/RV64I immediate generator with PC-relative target
// computation and a saturating count of unrecognised opcodes.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_tgt,
    output logic             out_tgt_valid,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    localparam bit RV64 = (XLEN == 64);

    logic [31:0]     dec_raw;
    logic [2:0]      dec_fmt;
    logic            dec_tv;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;

    logic            s1_valid;
    logic [XLEN-1:0] s1_imm;
    logic [2:0]      s1_fmt;
    logic [XLEN-1:0] s1_pc;
    logic            s1_tv;
    logic            s2_valid;

    logic            s1_adv;
    logic            s2_adv;
    logic            accept;

    // Immediates are assembled as 32-bit values; widening to XLEN then
    // replicates inst[31] (shamt values have bit 31 clear, so they zero-extend).
    always_comb begin
        dec_raw  = '0;
        dec_fmt  = FMT_ILL;
        dec_tv   = 1'b0;
        is_shift = (in_inst[13:12] == 2'b01);
        case (in_inst[6:0])
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_raw = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0010011: begin
                dec_fmt = FMT_I;
                if (is_shift)
                    dec_raw = RV64 ? {26'b0, in_inst[25:20]} : {27'b0, in_inst[24:20]};
                else
                    dec_raw = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0011011: begin
                if (RV64) begin
                    dec_fmt = FMT_I;
                    if (is_shift)
                        dec_raw = {27'b0, in_inst[24:20]};
                    else
                        dec_raw = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_raw = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_tv  = 1'b1;
                dec_raw = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_tv  = 1'b1;
                dec_raw = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
            end
            7'b0110111: begin
                dec_fmt = FMT_U;
                dec_raw = {in_inst[31:12], 12'b0};
            end
            7'b0010111: begin
                dec_fmt = FMT_U;
                dec_tv  = 1'b1;
                dec_raw = {in_inst[31:12], 12'b0};
            end
            7'b0110011: dec_fmt = FMT_NONE;
            7'b0111011: dec_fmt = RV64 ? FMT_NONE : FMT_ILL;
            default:    dec_fmt = FMT_ILL;
        endcase
    end

    assign dec_imm = XLEN'(signed'(dec_raw));

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_imm        <= '0;
            s1_fmt        <= FMT_NONE;
            s1_pc         <= '0;
            s1_tv         <= 1'b0;
            s2_valid      <= 1'b0;
            out_imm       <= '0;
            out_fmt       <= FMT_NONE;
            out_tgt       <= '0;
            out_tgt_valid <= 1'b0;
            illegal_cnt   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_imm <= dec_imm;
                    s1_fmt <= dec_fmt;
                    s1_pc  <= in_pc;
                    s1_tv  <= dec_tv;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_imm       <= s1_imm;
                    out_fmt       <= s1_fmt;
                    out_tgt       <= s1_tv ? s1_pc + s1_imm : '0;
                    out_tgt_valid <= s1_tv;
                end
            end
            if (accept && dec_fmt == FMT_ILL && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule
